// File: rtl/sar_scan_sequencer_pkg.sv
// Shared types and constants for the SAR scan sequencer: FSM encoding, averaging shift and
// default timing. Averaging build option: SAR_SCAN_AVG_EN.
package sar_scan_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StStart  = 3'd2,
    StWait   = 3'd3,
    StStore  = 3'd4,
    StDone   = 3'd5
  } state_e;

  localparam int unsigned AVG_SHIFT      = 2;
  localparam int unsigned DEF_ADC_WIDTH  = 8;
  localparam int unsigned DEF_NCH        = 4;
  localparam int unsigned DEF_CHW        = 2;
  localparam int unsigned DEF_SETTLE_CYC = 4;
  localparam int unsigned DEF_TMO_CYC    = 64;

  // One counter serves both settle and timeout, so size it for the larger of the two.
  function automatic int unsigned cnt_width(input int unsigned settle, input int unsigned tmo);
    int unsigned m;
    m = (settle > tmo) ? settle : tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sar_scan_sequencer_if.sv
// Control/ADC/result signal bundle of the scan sequencer; master is the sequencer side,
// slave is the system + ADC side.
interface sar_scan_sequencer_if
  import sar_scan_sequencer_pkg::*;
#(
  parameter int unsigned ADC_WIDTH = DEF_ADC_WIDTH,
  parameter int unsigned NCH       = DEF_NCH,
  parameter int unsigned CHW       = DEF_CHW
);
  logic                 trig;
  logic                 continuous;
  logic [NCH-1:0]       ch_mask;
  logic [CHW-1:0]       mux_sel;
  logic                 adc_start;
  logic                 adc_eoc;
  logic [ADC_WIDTH-1:0] adc_dout;
  logic                 res_valid;
  logic [CHW-1:0]       res_ch;
  logic [ADC_WIDTH-1:0] res_data;
  logic                 scan_done;
  logic                 busy;
  logic                 tmo_err;

  modport master (
    input  trig, continuous, ch_mask, adc_eoc, adc_dout,
    output mux_sel, adc_start, res_valid, res_ch, res_data, scan_done, busy, tmo_err
  );

  modport slave (
    output trig, continuous, ch_mask, adc_eoc, adc_dout,
    input  mux_sel, adc_start, res_valid, res_ch, res_data, scan_done, busy, tmo_err
  );

endinterface

// File: rtl/sar_scan_sequencer_next_ch.sv
// Combinational finder: lowest set mask bit strictly above idx_i, or the lowest set bit
// overall when lowest_i is high.
module sar_scan_sequencer_next_ch #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input  logic [NCH-1:0] mask_i,
  input  logic [CHW-1:0] idx_i,
  input  logic           lowest_i,
  output logic           found_o,
  output logic [CHW-1:0] ch_o
);

  // Walk downwards so the last match written is the lowest qualifying bit.
  always_comb begin
    found_o = 1'b0;
    ch_o    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i] && (lowest_i || (i > int'(idx_i)))) begin
        found_o = 1'b1;
        ch_o    = CHW'(i);
      end
    end
  end

endmodule

// File: rtl/sar_scan_sequencer.sv
// Multi-channel scan scheduler sharing one SAR ADC across NCH mux inputs.
// Define SAR_SCAN_AVG_EN to average 4 back-to-back conversions per channel.
module sar_scan_sequencer
  import sar_scan_sequencer_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = DEF_ADC_WIDTH,
  parameter int unsigned NCH        = DEF_NCH,
  parameter int unsigned CHW        = DEF_CHW,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned TMO_CYC    = DEF_TMO_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  sar_scan_sequencer_if.master bus_io
);

  localparam int unsigned CntW = cnt_width(SETTLE_CYC, TMO_CYC);

  state_e               state_q;
  logic                 trig_q;
  logic [NCH-1:0]       mask_q;
  logic [CHW-1:0]       mux_sel_q;
  logic [CHW-1:0]       res_ch_q;
  logic [ADC_WIDTH-1:0] res_data_q;
  logic                 adc_start_q;
  logic                 res_valid_q;
  logic                 scan_done_q;
  logic                 busy_q;
  logic                 tmo_err_q;
  logic [CntW-1:0]      cnt_q;

  logic                 trig_rise;
  logic                 low_found;
  logic [CHW-1:0]       low_ch;
  logic                 nxt_found;
  logic [CHW-1:0]       nxt_ch;

`ifdef SAR_SCAN_AVG_EN
  logic [ADC_WIDTH+1:0] acc_q;
  logic [ADC_WIDTH+1:0] acc_sum;
  logic [AVG_SHIFT-1:0] samp_q;

  assign acc_sum = acc_q + {2'b00, bus_io.adc_dout};
`endif

  assign trig_rise = bus_io.trig & ~trig_q;

  // Lowest enabled channel of the live mask, used when a scan (re)starts.
  sar_scan_sequencer_next_ch #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_low_ch (
    .mask_i   (bus_io.ch_mask),
    .idx_i    ('0),
    .lowest_i (1'b1),
    .found_o  (low_found),
    .ch_o     (low_ch)
  );

  sar_scan_sequencer_next_ch #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_nxt_ch (
    .mask_i   (mask_q),
    .idx_i    (mux_sel_q),
    .lowest_i (1'b0),
    .found_o  (nxt_found),
    .ch_o     (nxt_ch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      trig_q      <= 1'b0;
      mask_q      <= '0;
      mux_sel_q   <= '0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      adc_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      cnt_q       <= '0;
`ifdef SAR_SCAN_AVG_EN
      acc_q       <= '0;
      samp_q      <= '0;
`endif
    end else begin
      trig_q      <= bus_io.trig;
      adc_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      scan_done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (trig_rise && low_found) begin
            mask_q    <= bus_io.ch_mask;
            mux_sel_q <= low_ch;
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StSettle;
          end
        end

        StSettle: begin
          if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
            cnt_q       <= '0;
            adc_start_q <= 1'b1;
            state_q     <= StStart;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StStart: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end

        StWait: begin
          if (bus_io.adc_eoc) begin
`ifdef SAR_SCAN_AVG_EN
            if (&samp_q) begin
              res_valid_q <= 1'b1;
              res_ch_q    <= mux_sel_q;
              res_data_q  <= acc_sum[ADC_WIDTH+1:AVG_SHIFT];
              acc_q       <= '0;
              samp_q      <= '0;
              state_q     <= StStore;
            end else begin
              // Next sample goes straight out: the mux has not moved, so no resettle.
              acc_q       <= acc_sum;
              samp_q      <= samp_q + 1'b1;
              cnt_q       <= '0;
              adc_start_q <= 1'b1;
              state_q     <= StStart;
            end
`else
            res_valid_q <= 1'b1;
            res_ch_q    <= mux_sel_q;
            res_data_q  <= bus_io.adc_dout;
            state_q     <= StStore;
`endif
          end else if (cnt_q == CntW'(TMO_CYC - 1)) begin
            tmo_err_q <= 1'b1;
`ifdef SAR_SCAN_AVG_EN
            acc_q     <= '0;
            samp_q    <= '0;
`endif
            state_q   <= StStore;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StStore: begin
          if (nxt_found) begin
            mux_sel_q <= nxt_ch;
            cnt_q     <= '0;
            state_q   <= StSettle;
          end else begin
            scan_done_q <= 1'b1;
            state_q     <= StDone;
          end
        end

        StDone: begin
          if (bus_io.continuous && low_found) begin
            mask_q    <= bus_io.ch_mask;
            mux_sel_q <= low_ch;
            cnt_q     <= '0;
            state_q   <= StSettle;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.mux_sel   = mux_sel_q;
  assign bus_io.adc_start = adc_start_q;
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.res_ch    = res_ch_q;
  assign bus_io.res_data  = res_data_q;
  assign bus_io.scan_done = scan_done_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// Bench for sar_scan_sequencer: ADC behavioural model, result monitor and directed plus
// randomized scans checked against a channel-list reference.
`timescale 1ns/1ps
module tb_sar_scan_sequencer;

  localparam int unsigned AW     = 8;
  localparam int unsigned NCH    = 4;
  localparam int unsigned CHW    = 2;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 64;
`ifdef SAR_SCAN_AVG_EN
  localparam int unsigned NSAMP  = 4;
`else
  localparam int unsigned NSAMP  = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sar_scan_sequencer_if #(.ADC_WIDTH(AW), .NCH(NCH), .CHW(CHW)) bus ();

  sar_scan_sequencer #(
    .ADC_WIDTH  (AW),
    .NCH        (NCH),
    .CHW        (CHW),
    .SETTLE_CYC (SETTLE),
    .TMO_CYC    (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // ADC model state
  logic           adc_eoc_m  = 1'b0;
  logic [AW-1:0]  adc_dout_m = '0;
  int             conv_fixed = 0;
  int             withhold_ch = -1;
  logic [7:0]     dbase = 8'h10;
  int             pend = 0;
  logic [7:0]     pend_data = '0;
  int             samp_k = 0;
  logic [CHW-1:0] last_mux = '0;

  assign bus.adc_eoc  = adc_eoc_m;
  assign bus.adc_dout = adc_dout_m;

  // Monitor state
  logic [CHW-1:0] got_ch[$];
  logic [7:0]     got_data[$];
  int             n_done = 0;
  int             n_start = 0;
  int             first_start_ch = -1;
  int             cyc = 0;
  int             start_time = 0;
  int             tmo_lat = -1;
  int             stab = 0;
  int             rv_gap = 0;
  bit             rv_seen = 1'b0;
  logic           prev_start = 1'b0;
  logic           prev_tmo = 1'b0;
  logic [CHW-1:0] prev_mux = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result of one channel is the truncated mean of its NSAMP samples.
  function automatic logic [7:0] exp_data(input logic [7:0] base, input int ch);
    int s;
    logic [7:0] smp;
    s = 0;
    for (int k = 0; k < int'(NSAMP); k++) begin
      smp = base + 8'(ch) + 8'(k);
      s += int'(smp);
    end
    return 8'(s / int'(NSAMP));
  endfunction

  // ADC: conversion result appears a few cycles after each start pulse as a 1-cycle eoc.
  always @(negedge clk) begin
    adc_eoc_m = 1'b0;
    if (bus.mux_sel != last_mux || bus.res_valid) samp_k = 0;
    last_mux = bus.mux_sel;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        adc_eoc_m  = 1'b1;
        adc_dout_m = pend_data;
      end
    end
    if (bus.adc_start) begin
      pend_data = dbase + 8'(bus.mux_sel) + 8'(samp_k);
      samp_k++;
      if (int'(bus.mux_sel) == withhold_ch) pend = 0;
      else pend = (conv_fixed != 0) ? conv_fixed : int'($urandom_range(6, 14));
    end
  end

  always @(negedge clk) begin
    if (bus.mux_sel == prev_mux) stab++;
    else stab = 0;
    prev_mux = bus.mux_sel;
    if (rst) rv_seen = 1'b0;
    if (bus.res_valid) begin
      got_ch.push_back(bus.res_ch);
      got_data.push_back(bus.res_data);
      rv_gap  = 0;
      rv_seen = 1'b1;
    end else begin
      rv_gap++;
    end
    if (bus.scan_done) begin
      n_done++;
      rv_seen = 1'b0;
    end
    if (bus.adc_start) begin
      if (n_start == 0) first_start_ch = int'(bus.mux_sel);
      n_start++;
      chk("start_one_cycle", 32'(prev_start), 0);
      chk("settle_stable", 32'(stab >= int'(SETTLE)), 1);
      if (rv_seen) chk("store_to_start", rv_gap, SETTLE + 1);
      rv_seen    = 1'b0;
      start_time = cyc;
    end
    if (bus.tmo_err && !prev_tmo) tmo_lat = cyc - start_time;
    prev_tmo   = bus.tmo_err;
    prev_start = bus.adc_start;
    cyc++;
  end

  task automatic pulse_trig();
    @(negedge clk);
    bus.trig = 1'b1;
    @(negedge clk);
    bus.trig = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < budget);
    chk("idle_within_budget", 32'(bus.busy), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mux_sel"}, 32'(bus.mux_sel), 0);
    chk({tag, "_adc_start"}, 32'(bus.adc_start), 0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_res_ch"}, 32'(bus.res_ch), 0);
    chk({tag, "_res_data"}, 32'(bus.res_data), 0);
    chk({tag, "_scan_done"}, 32'(bus.scan_done), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_tmo_err"}, 32'(bus.tmo_err), 0);
  endtask

  task automatic run_scan(input logic [3:0] mask, input bit glitch, input string tag);
    int exp_ch[$];
    int exp_starts;
    int low;
    exp_starts = 0;
    low = -1;
    got_ch.delete();
    got_data.delete();
    n_done = 0;
    n_start = 0;
    first_start_ch = -1;
    for (int c = 0; c < int'(NCH); c++) begin
      if (mask[c]) begin
        if (low < 0) low = c;
        if (c == withhold_ch) exp_starts += 1;
        else begin
          exp_starts += int'(NSAMP);
          exp_ch.push_back(c);
        end
      end
    end
    bus.ch_mask = mask;
    pulse_trig();
    if (glitch) begin
      repeat (6) @(negedge clk);
      bus.ch_mask = ~mask;
      pulse_trig();
    end
    wait_idle(6000);
    chk({tag, "_count"}, got_ch.size(), exp_ch.size());
    for (int i = 0; i < exp_ch.size() && i < got_ch.size(); i++) begin
      chk({tag, "_ch"}, 32'(got_ch[i]), exp_ch[i]);
      chk({tag, "_data"}, 32'(got_data[i]), 32'(exp_data(dbase, exp_ch[i])));
    end
    chk({tag, "_scan_done"}, n_done, 1);
    chk({tag, "_starts"}, n_start, exp_starts);
    chk({tag, "_first_ch"}, first_start_ch, low);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    int done0;
    bit busy_seen;
    bus.trig       = 1'b0;
    bus.continuous = 1'b0;
    bus.ch_mask    = '0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    dbase = 8'h10;
    run_scan(4'b1011, 1'b0, "mask1011");
`ifdef SAR_SCAN_AVG_EN
    if (got_data.size() > 0) chk("avg_ch0_value", 32'(got_data[0]), 32'h11);
`endif

    n_start = 0;
    busy_seen = 1'b0;
    bus.ch_mask = '0;
    pulse_trig();
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1'b1;
    end
    chk("mask0_busy", 32'(busy_seen), 0);
    chk("mask0_starts", n_start, 0);

    withhold_ch = 1;
    tmo_lat = -1;
    run_scan(4'b0011, 1'b0, "timeout");
    chk("timeout_flag", 32'(bus.tmo_err), 1);
    chk("timeout_latency", tmo_lat, TMO + 1);
    withhold_ch = -1;

    for (int it = 0; it < 6; it++) begin
      dbase = 8'($urandom);
      run_scan(4'($urandom_range(1, 15)), it[0], "random");
      chk("random_tmo_clear", 32'(bus.tmo_err), 0);
    end

    dbase = 8'h40;
    got_ch.delete();
    got_data.delete();
    bus.continuous = 1'b1;
    bus.ch_mask = 4'b0001;
    pulse_trig();
    n = 0;
    r = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.res_valid) r++;
    end while (r < 3 && n < 3000);
    chk("cont_results_seen", r, 3);
    bus.continuous = 1'b0;
    done0 = n_done;
    wait_idle(3000);
    @(negedge clk);
    chk("cont_final_done", n_done - done0, 1);
    chk("cont_count", got_ch.size(), 3);
    foreach (got_ch[i]) begin
      chk("cont_ch", 32'(got_ch[i]), 0);
      chk("cont_data", 32'(got_data[i]), 32'(exp_data(dbase, 0)));
    end

    conv_fixed = 12;
    bus.ch_mask = 4'b0100;
    pulse_trig();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.adc_start && bus.mux_sel == 2'd2) && n < 200);
    chk("rst_reach_ch2", 32'(bus.adc_start), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midscan_reset");
    rst = 1'b0;
    got_ch.delete();
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1'b1;
    end
    chk("late_eoc_results", got_ch.size(), 0);
    chk("late_eoc_busy", 32'(busy_seen), 0);
    conv_fixed = 0;
    run_scan(4'b0101, 1'b0, "rescan");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
